f2int_fsm: RTL and testbench
============================

# f2int_fsm

Multi-cycle IEEE-754 single-precision to 32-bit signed integer converter, truncating toward zero. Sits directly downstream of the fractional-part checker: it takes the same 32-bit float and that stage's ready pulse as its start strobe. It produces the integer, saturation/NaN/inexact flags and a one-cycle ready pulse for the next stage. The mantissa is aligned by an iterative one-bit-per-cycle shifter, so latency depends on the exponent.

## Interface
- No parameters; widths are fixed by the float format (8-bit exponent, 23-bit mantissa, bias 127).
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- num  in  32  IEEE-754 single input; sampled only on the accepting edge
- r_i  in  1  start strobe (upstream ready); honoured only in IDLE
- val  out  32  two's-complement result; held until the next DONE
- ovf  out  1  result saturated (|x| too large, or ±Inf)
- nan  out  1  input was NaN
- inexact  out  1  nonzero bits were discarded by truncation
- busy  out  1  high in every state except IDLE
- r_o  out  1  registered; high for exactly one cycle when val and flags are valid

## Operation
- Reset: state IDLE; val = 0; ovf, nan, inexact, busy and r_o = 0. Reset mid-conversion aborts it, and no r_o is issued.
- IDLE: on r_i=1, latch num into s, e, m; clear the sticky bit; go to DECODE. Otherwise stay.
- DECODE: classify the latched value (precedence top to bottom):
  - e=255, m≠0: result 0, nan=1; go to SIGN with the negate step suppressed.
  - e=255, m=0: ovf=1; result 0x7FFFFFFF if s=0, else 0x80000000; go to SIGN, no negate.
  - e=158, m=0, s=1: exact −2^31; result 0x80000000, ovf=0; go to SIGN, no negate.
  - e≥158: ovf=1; saturate by sign as for Inf; go to SIGN, no negate.
  - e<127 (zero, denormal or |x|<1): magnitude 0; inexact = (e≠0 || m≠0); go to SIGN.
  - Otherwise: acc = {8'b0, 1'b1, m}, k = e−127 (0..30).
    - If k≥23: shift left, N = k−23 (0..7).
    - Else: shift right, N = 23−k (1..23).
    - Go to SHIFT if N>0, else to SIGN.
- SHIFT: each cycle shift acc one bit and decrement N.
  - Right shift: the bit shifted out ORs into sticky.
  - On the cycle N reaches 0, go to SIGN.
- SIGN: if s=1 and negate is not suppressed, val = −acc (two's complement); else val = acc.
  - inexact = sticky, or the DECODE value.
  - Register all flags; set r_o=1; go to DONE.
- DONE: r_o held for this one cycle, then cleared; return to IDLE.
- r_i is ignored in DECODE, SHIFT, SIGN and DONE. Back-to-back operation is accepted from the first IDLE cycle after DONE.
- −0.0 gives val=0 with all flags 0.
- acc is 32 bits wide; at most bit 30 is set before negation, so no intermediate overflow.

## Timing
- Counting the edge that samples r_i as edge 0, r_o rises at edge N+2 and falls at edge N+3.
- N = 0 for all special cases, so those have latency 2.
- Worst case (k=0): N=23, so r_o rises at edge 25.
- val and flags change only on the edge that raises r_o.
- busy rises at edge 0 and falls at edge N+3.

## Structure
- Shared package f2i_pkg:
  - State enum: IDLE, DECODE, SHIFT, SIGN, DONE.
  - Constants: BIAS=127, EXP_W=8, MANT_W=23, INT_MAX=32'h7FFFFFFF, INT_MIN=32'h80000000.
- One combinational sub-module, f2i_classify: maps (s, e, m) to the special-case code, shift direction, N and the initial acc.
- The FSM, shifter, sticky logic and negation stay in the top module.

## Test plan
- 0x40700000 (3.75): val=3, inexact=1, ovf=0, nan=0; r_o at edge 24 (N=22).
- 0xBF800000 (−1.0): val=0xFFFFFFFF, inexact=0. 0x4B800001: val=0x01000002, inexact=0, r_o at edge 3 (left shift, N=1).
- 0xCF000000 (−2^31): val=0x80000000, ovf=0. 0x4F000000 (2^31): val=0x7FFFFFFF, ovf=1. 0xFF800000 (−Inf): val=0x80000000, ovf=1. All with r_o at edge 2.
- 0x7FC00000 (NaN): val=0, nan=1, ovf=0. 0x3F000000 (0.5): val=0, inexact=1. 0x80000000 (−0): val=0, all flags 0.
- 0x40700000 with r_i held high continuously: exactly one conversion per r_o pulse; the next input is accepted in the IDLE cycle after DONE; inputs presented while busy=1 have no effect.
- rst_n pulsed low during SHIFT of a 3.75 conversion: all outputs 0 immediately, no r_o, and the next r_i converts correctly.

Source files
------------

// File: rtl/f2int_fsm_pkg.sv
// Shared types and constants for the float-to-int converter slice.
package f2i_pkg;
   localparam int unsigned      EXP_W   = 8;
   localparam int unsigned      MANT_W  = 23;
   localparam logic [EXP_W-1:0] BIAS    = 8'd127;
   localparam logic [31:0]      INT_MAX = 32'h7FFF_FFFF;
   localparam logic [31:0]      INT_MIN = 32'h8000_0000;

   typedef enum logic [2:0] {IDLE, DECODE, SHIFT, SIGN, DONE} state_e;

   // Classification result; everything except NORM and SMALL skips negation.
   typedef enum logic [2:0] {CLS_NORM, CLS_NAN, CLS_SAT, CLS_MIN, CLS_SMALL} cls_e;
endpackage

// File: rtl/f2int_fsm_if.sv
// Handshake/data bundle between upstream checker, converter and next stage.
interface f2int_fsm_if;
   logic [31:0] num;
   logic        r_i;
   logic [31:0] val;
   logic        ovf;
   logic        nan;
   logic        inexact;
   logic        busy;
   logic        r_o;

   modport master (output num, r_i, input val, ovf, nan, inexact, busy, r_o);
   modport slave  (input num, r_i, output val, ovf, nan, inexact, busy, r_o);
endinterface

// File: rtl/f2int_fsm_classify.sv
// Combinational decode of a latched float into special-case code, shift plan and initial acc.
module f2i_classify
   import f2i_pkg::*;
(
   input  logic              s_i,
   input  logic [EXP_W-1:0]  e_i,
   input  logic [MANT_W-1:0] m_i,
   output cls_e              cls_o,
   output logic              left_o,
   output logic [4:0]        n_o,
   output logic [31:0]       acc_o,
   output logic              inexact_o
);
   logic [EXP_W-1:0] k;
   assign k = e_i - BIAS;

   always_comb begin
      cls_o     = CLS_NORM;
      left_o    = 1'b0;
      n_o       = '0;
      acc_o     = {8'b0, 1'b1, m_i};
      inexact_o = 1'b0;
      if (e_i == '1 && m_i != '0) begin
         cls_o = CLS_NAN;
         acc_o = '0;
      end else if (e_i == '1) begin
         cls_o = CLS_SAT;
         acc_o = s_i ? INT_MIN : INT_MAX;
      end else if (e_i == 8'd158 && m_i == '0 && s_i) begin
         cls_o = CLS_MIN;
         acc_o = INT_MIN;
      end else if (e_i >= 8'd158) begin
         cls_o = CLS_SAT;
         acc_o = s_i ? INT_MIN : INT_MAX;
      end else if (e_i < BIAS) begin
         cls_o     = CLS_SMALL;
         acc_o     = '0;
         inexact_o = (e_i != '0) || (m_i != '0);
      end else if (k >= 8'd23) begin
         left_o = 1'b1;
         n_o    = 5'(k - 8'd23);
      end else begin
         n_o = 5'(8'd23 - k);
      end
   end
endmodule

// File: rtl/f2int_fsm.sv
// Multi-cycle float32 -> int32 converter (truncate toward zero) with a one-bit-per-cycle aligner.
module f2int_fsm
   import f2i_pkg::*;
(
   input logic        clk,
   input logic        rst_n,
   f2int_fsm_if.slave bus
);
   state_e              state_q, state_d;
   logic                s_q, s_d;
   logic [EXP_W-1:0]    e_q, e_d;
   logic [MANT_W-1:0]   m_q, m_d;
   logic [31:0]         acc_q, acc_d;
   logic [4:0]          n_q, n_d;
   logic                left_q, left_d;
   logic                sticky_q, sticky_d;
   logic                noneg_q, noneg_d;
   logic                povf_q, povf_d, pnan_q, pnan_d, pinex_q, pinex_d;
   logic [31:0]         val_q, val_d;
   logic                ovf_q, ovf_d, nan_q, nan_d, inex_q, inex_d;
   logic                busy_q, busy_d, r_o_q, r_o_d;

   cls_e                cls;
   logic                cls_left, cls_inex;
   logic [4:0]          cls_n;
   logic [31:0]         cls_acc;

   f2i_classify u_classify (
      .s_i       (s_q),
      .e_i       (e_q),
      .m_i       (m_q),
      .cls_o     (cls),
      .left_o    (cls_left),
      .n_o       (cls_n),
      .acc_o     (cls_acc),
      .inexact_o (cls_inex)
   );

   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      e_d      = e_q;
      m_d      = m_q;
      acc_d    = acc_q;
      n_d      = n_q;
      left_d   = left_q;
      sticky_d = sticky_q;
      noneg_d  = noneg_q;
      povf_d   = povf_q;
      pnan_d   = pnan_q;
      pinex_d  = pinex_q;
      val_d    = val_q;
      ovf_d    = ovf_q;
      nan_d    = nan_q;
      inex_d   = inex_q;
      r_o_d    = 1'b0;
      case (state_q)
         IDLE: if (bus.r_i) begin
            s_d      = bus.num[31];
            e_d      = bus.num[30:23];
            m_d      = bus.num[22:0];
            sticky_d = 1'b0;
            state_d  = DECODE;
         end
         DECODE: begin
            acc_d   = cls_acc;
            n_d     = cls_n;
            left_d  = cls_left;
            noneg_d = (cls != CLS_NORM) && (cls != CLS_SMALL);
            povf_d  = (cls == CLS_SAT);
            pnan_d  = (cls == CLS_NAN);
            pinex_d = cls_inex;
            state_d = (cls_n != '0) ? SHIFT : SIGN;
         end
         SHIFT: begin
            if (left_q) begin
               acc_d = acc_q << 1;
            end else begin
               acc_d    = acc_q >> 1;
               sticky_d = sticky_q | acc_q[0];
            end
            n_d = n_q - 5'd1;
            if (n_q == 5'd1) state_d = SIGN;
         end
         SIGN: begin
            val_d   = (s_q && !noneg_q) ? (~acc_q + 32'd1) : acc_q;
            ovf_d   = povf_q;
            nan_d   = pnan_q;
            inex_d  = sticky_q | pinex_q;
            r_o_d   = 1'b1;
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         s_q      <= 1'b0;
         e_q      <= '0;
         m_q      <= '0;
         acc_q    <= '0;
         n_q      <= '0;
         left_q   <= 1'b0;
         sticky_q <= 1'b0;
         noneg_q  <= 1'b0;
         povf_q   <= 1'b0;
         pnan_q   <= 1'b0;
         pinex_q  <= 1'b0;
         val_q    <= '0;
         ovf_q    <= 1'b0;
         nan_q    <= 1'b0;
         inex_q   <= 1'b0;
         busy_q   <= 1'b0;
         r_o_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         s_q      <= s_d;
         e_q      <= e_d;
         m_q      <= m_d;
         acc_q    <= acc_d;
         n_q      <= n_d;
         left_q   <= left_d;
         sticky_q <= sticky_d;
         noneg_q  <= noneg_d;
         povf_q   <= povf_d;
         pnan_q   <= pnan_d;
         pinex_q  <= pinex_d;
         val_q    <= val_d;
         ovf_q    <= ovf_d;
         nan_q    <= nan_d;
         inex_q   <= inex_d;
         busy_q   <= busy_d;
         r_o_q    <= r_o_d;
      end
   end

   assign bus.val     = val_q;
   assign bus.ovf     = ovf_q;
   assign bus.nan     = nan_q;
   assign bus.inexact = inex_q;
   assign bus.busy    = busy_q;
   assign bus.r_o     = r_o_q;
endmodule

// File: tb/tb_f2int_fsm.sv
// Directed-vector bench for f2int_fsm with hand-computed results and edge-counted latency.
module tb_f2int_fsm;
   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   f2int_fsm_if bus ();

   f2int_fsm dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Edge 0 is the posedge that samples r_i; latency is the edge index of r_o rising.
   task automatic convert(input string tag, input logic [31:0] f, input logic [31:0] ev,
                          input logic eo, input logic en, input logic ei, input int el);
      int lat;
      lat = -1;
      @(negedge clk);
      bus.num = f;
      bus.r_i = 1'b1;
      @(posedge clk);
      #1;
      bus.r_i = 1'b0;
      bus.num = 32'hDEAD_BEEF;
      chk({tag, ".busy_rise"}, 32'(bus.busy), 32'd1);
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (bus.r_o) begin
            lat = c;
            break;
         end
      end
      chk({tag, ".latency"}, 32'(lat), 32'(el));
      chk({tag, ".val"}, bus.val, ev);
      chk({tag, ".ovf"}, 32'(bus.ovf), 32'(eo));
      chk({tag, ".nan"}, 32'(bus.nan), 32'(en));
      chk({tag, ".inexact"}, 32'(bus.inexact), 32'(ei));
      @(posedge clk);
      #1;
      chk({tag, ".r_o_fall"}, 32'(bus.r_o), 32'd0);
      chk({tag, ".busy_fall"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int pulses, first, second, stray;
      bus.num = '0;
      bus.r_i = 1'b0;
      rst_n   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.val", bus.val, 32'd0);
      chk("reset.flags", {28'd0, bus.ovf, bus.nan, bus.inexact, bus.busy}, 32'd0);
      chk("reset.r_o", 32'(bus.r_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      convert("f3p75",   32'h4070_0000, 32'h0000_0003, 1'b0, 1'b0, 1'b1, 24);
      convert("neg1",    32'hBF80_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 25);
      convert("lsh1",    32'h4B80_0001, 32'h0100_0002, 1'b0, 1'b0, 1'b0, 3);
      convert("negmin",  32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 2);
      convert("pos2p31", 32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 2);
      convert("neginf",  32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 2);
      convert("posinf",  32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 2);
      convert("nan",     32'h7FC0_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 2);
      convert("half",    32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 2);
      convert("denorm",  32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 2);
      convert("negzero", 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 2);

      // r_i held high: first conversion ignores busy-time num changes, second accepted after DONE.
      pulses = 0;
      first  = -1;
      second = -1;
      @(negedge clk);
      bus.num = 32'h4070_0000;
      bus.r_i = 1'b1;
      @(posedge clk);
      #1;
      bus.num = 32'hFF80_0000;
      for (int c = 1; c <= 29; c++) begin
         @(posedge clk);
         #1;
         if (bus.r_o) begin
            pulses++;
            if (first < 0) begin
               first = c;
               chk("held.first_val", bus.val, 32'h0000_0003);
               chk("held.first_inexact", 32'(bus.inexact), 32'd1);
               chk("held.first_ovf", 32'(bus.ovf), 32'd0);
               bus.num = 32'h4B80_0001;
            end else begin
               second = c;
               chk("held.second_val", bus.val, 32'h0100_0002);
               chk("held.second_inexact", 32'(bus.inexact), 32'd0);
            end
         end
         if (c == 25) chk("held.idle_gap", 32'(bus.busy), 32'd0);
      end
      bus.r_i = 1'b0;
      chk("held.first_edge", 32'(first), 32'd24);
      chk("held.second_edge", 32'(second), 32'd29);
      chk("held.pulses", 32'(pulses), 32'd2);
      repeat (2) @(posedge clk);
      #1;
      chk("held.end_busy", 32'(bus.busy), 32'd0);

      // Reset pulse during SHIFT aborts without r_o; outputs clear at once.
      @(negedge clk);
      bus.num = 32'h4070_0000;
      bus.r_i = 1'b1;
      @(posedge clk);
      #1;
      bus.r_i = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("abort.pre_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort.val", bus.val, 32'd0);
      chk("abort.flags", {28'd0, bus.ovf, bus.nan, bus.inexact, bus.busy}, 32'd0);
      chk("abort.r_o", 32'(bus.r_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      stray = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk);
         #1;
         if (bus.r_o || bus.busy) stray++;
      end
      chk("abort.no_r_o", 32'(stray), 32'd0);
      convert("after_abort", 32'h4070_0000, 32'h0000_0003, 1'b0, 1'b0, 1'b1, 24);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
